// File: rtl/mux_scan_seq.sv
// Scans an 8-bit word out through a downstream 8:1 mux: holds the word on i0..i7 and steps
// the select s2..s0 across all channels, HOLD cycles per channel, with back-to-back reload.
module mux_scan_seq #(
    parameter int unsigned HOLD      = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       i0,
    output logic       i1,
    output logic       i2,
    output logic       i3,
    output logic       i4,
    output logic       i5,
    output logic       i6,
    output logic       i7,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       last,
    output logic       done
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    localparam logic [2:0] FirstChan = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] FinalChan = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [3:0] HoldMax   = 4'(HOLD - 1);

    state_e     state_q, state_d;
    logic [2:0] chan_q, chan_d;
    logic [3:0] hcnt_q, hcnt_d;
    logic [7:0] data_q, data_d;
    logic       done_q;
    logic       xfer;

    assign xfer = load_valid && load_ready;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            chan_q  <= 3'd0;
            hcnt_q  <= 4'd0;
            data_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            hcnt_q  <= hcnt_d;
            data_q  <= data_d;
            done_q  <= last;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        hcnt_d  = hcnt_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) state_d = StScan;
            end
            StScan: begin
                if (last && !xfer) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (xfer) begin
            data_d = load_data;
            chan_d = FirstChan;
            hcnt_d = 4'd0;
        end else if (state_q == StScan && !last) begin
            if (hcnt_q == HoldMax) begin
                hcnt_d = 4'd0;
                chan_d = MSB_FIRST ? chan_q - 3'd1 : chan_q + 3'd1;
            end else begin
                hcnt_d = hcnt_q + 4'd1;
            end
        end
    end

    // Output logic
    always_comb begin
        busy       = (state_q == StScan);
        last       = (state_q == StScan) && (chan_q == FinalChan) && (hcnt_q == HoldMax);
        load_ready = rst_n && ((state_q == StIdle) || last);
        done       = done_q;
        {s2, s1, s0} = chan_q;
        {i7, i6, i5, i4, i3, i2, i1, i0} = data_q;
    end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench for mux_scan_seq: dut 0 uses HOLD=1/LSB-first, dut 1 uses HOLD=3/MSB-first.
module tb_mux_scan_seq;

    typedef struct packed {
        logic       busy;
        logic [2:0] sel;
        logic       dbit;
        logic       last;
        logic       done;
    } rec_t;

    logic        clk = 1'b0;
    logic        lv[2];
    logic [7:0]  ld[2];
    logic        rn[2];
    logic [14:0] obs[2];  // {ready, busy, last, done, sel[2:0], ivec[7:0]}
    logic [7:0]  iv_a, iv_b;
    logic        rdy_a, rdy_b, busy_a, busy_b, last_a, last_b, done_a, done_b;
    logic        s0_a, s1_a, s2_a, s0_b, s1_b, s2_b;

    rec_t q_a[$];
    rec_t q_b[$];
    bit   pend[2];
    logic [2:0] fin_sel[2];
    logic       fin_bit[2];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mux_scan_seq #(.HOLD(1), .MSB_FIRST(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rn[0]), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(rdy_a),
        .i0(iv_a[0]), .i1(iv_a[1]), .i2(iv_a[2]), .i3(iv_a[3]),
        .i4(iv_a[4]), .i5(iv_a[5]), .i6(iv_a[6]), .i7(iv_a[7]),
        .s0(s0_a), .s1(s1_a), .s2(s2_a), .busy(busy_a), .last(last_a), .done(done_a)
    );

    mux_scan_seq #(.HOLD(3), .MSB_FIRST(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rn[1]), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(rdy_b),
        .i0(iv_b[0]), .i1(iv_b[1]), .i2(iv_b[2]), .i3(iv_b[3]),
        .i4(iv_b[4]), .i5(iv_b[5]), .i6(iv_b[6]), .i7(iv_b[7]),
        .s0(s0_b), .s1(s1_b), .s2(s2_b), .busy(busy_b), .last(last_b), .done(done_b)
    );

    assign obs[0] = {rdy_a, busy_a, last_a, done_a, s2_a, s1_a, s0_a, iv_a};
    assign obs[1] = {rdy_b, busy_b, last_b, done_b, s2_b, s1_b, s0_b, iv_b};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic push(input int d, input rec_t r);
        rec_t e;
        e = r;
        if (pend[d]) begin
            e.done  = 1'b1;
            pend[d] = 1'b0;
        end
        if (d == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    // Expected per-cycle records for one full scan of data
    task automatic exp_scan(input int d, input logic [7:0] data, input int hold, input bit msb);
        rec_t r;
        int   ch;
        for (int k = 0; k < 8; k++) begin
            ch = msb ? 7 - k : k;
            for (int c = 0; c < hold; c++) begin
                r.busy = 1'b1;
                r.sel  = 3'(ch);
                r.dbit = data[ch];
                r.last = (k == 7) && (c == hold - 1);
                r.done = 1'b0;
                push(d, r);
            end
        end
        pend[d]    = 1'b1;
        fin_sel[d] = msb ? 3'd0 : 3'd7;
        fin_bit[d] = msb ? data[0] : data[7];
    endtask

    // Scan ends into idle: done pulses with busy low and final select/data held
    task automatic flush(input int d);
        rec_t r;
        if (pend[d]) begin
            pend[d] = 1'b0;
            r = '{busy: 1'b0, sel: fin_sel[d], dbit: fin_bit[d], last: 1'b0, done: 1'b1};
            push(d, r);
        end
    endtask

    task automatic load(input int d, input logic [7:0] data);
        lv[d] = 1'b1;
        ld[d] = data;
        @(posedge clk);
        #1 lv[d] = 1'b0;
    endtask

    task automatic load_b2b(input int d, input logic [7:0] a, input logic [7:0] b, input int hold);
        lv[d] = 1'b1;
        ld[d] = a;
        @(posedge clk);
        #1 ld[d] = b;
        repeat (8 * hold) @(posedge clk);
        #1 lv[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (obs[d][13] === 1'b1 || obs[d][11] === 1'b1) begin
                rec_t got;
                rec_t e;
                got.busy = obs[d][13];
                got.sel  = obs[d][10:8];
                got.dbit = obs[d][obs[d][10:8]];
                got.last = obs[d][12];
                got.done = obs[d][11];
                if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
                    n_total++;
                    $display("FAIL dut%0d_unexpected: got %0h expected no output at %0t",
                             d, got, $time);
                end else begin
                    e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                    check($sformatf("dut%0d_cycle{busy,sel,bit,last,done}", d),
                          {25'd0, got}, {25'd0, e});
                end
            end
        end
    end

    initial begin
        lv = '{1'b0, 1'b0};
        ld = '{8'h00, 8'h00};
        rn = '{1'b0, 1'b0};
        pend = '{1'b0, 1'b0};
        idle(2);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_rst_sel", d), {29'd0, obs[d][10:8]}, 32'd0);
            check($sformatf("dut%0d_rst_ivec", d), {24'd0, obs[d][7:0]}, 32'd0);
            check($sformatf("dut%0d_rst_busy_last_done", d), {29'd0, obs[d][13:11]}, 32'd0);
            check($sformatf("dut%0d_rst_ready", d), {31'd0, obs[d][14]}, 32'd0);
        end
        rn = '{1'b1, 1'b1};
        #1;
        check("dut0_ready_after_release", {31'd0, obs[0][14]}, 32'd1);
        check("dut1_ready_after_release", {31'd0, obs[1][14]}, 32'd1);

        // Basic LSB-first scan of A5
        exp_scan(0, 8'hA5, 1, 1'b0);
        flush(0);
        load(0, 8'hA5);
        idle(12);

        // load_valid held high: second word taken on the last cycle
        exp_scan(0, 8'h0F, 1, 1'b0);
        exp_scan(0, 8'hF0, 1, 1'b0);
        flush(0);
        load_b2b(0, 8'h0F, 8'hF0, 1);
        idle(12);

        // Mid-scan load_valid is ignored
        exp_scan(0, 8'h5A, 1, 1'b0);
        flush(0);
        load(0, 8'h5A);
        idle(3);
        lv[0] = 1'b1;
        ld[0] = 8'hFF;
        #1 check("dut0_midscan_ready", {31'd0, obs[0][14]}, 32'd0);
        idle(1);
        lv[0] = 1'b0;
        check("dut0_midscan_ivec", {24'd0, obs[0][7:0]}, 32'h5A);
        check("dut0_midscan_sel", {29'd0, obs[0][10:8]}, 32'd4);
        idle(10);

        // Reset at chan=4 aborts the scan with no done pulse
        exp_scan(0, 8'hA5, 1, 1'b0);
        flush(0);
        load(0, 8'hA5);
        idle(4);
        rn[0] = 1'b0;
        idle(1);
        q_a.delete();
        pend[0] = 1'b0;
        check("dut0_abort_sel", {29'd0, obs[0][10:8]}, 32'd0);
        check("dut0_abort_ivec", {24'd0, obs[0][7:0]}, 32'd0);
        check("dut0_abort_busy_done", {30'd0, obs[0][13], obs[0][11]}, 32'd0);
        check("dut0_abort_ready_in_reset", {31'd0, obs[0][14]}, 32'd0);
        rn[0] = 1'b1;
        #1 check("dut0_ready_after_abort", {31'd0, obs[0][14]}, 32'd1);
        idle(10);

        // HOLD=3 MSB-first single scan, then back-to-back 80 -> 01
        exp_scan(1, 8'h01, 3, 1'b1);
        flush(1);
        load(1, 8'h01);
        idle(30);
        exp_scan(1, 8'h80, 3, 1'b1);
        exp_scan(1, 8'h01, 3, 1'b1);
        flush(1);
        load_b2b(1, 8'h80, 8'h01, 3);
        idle(30);

        for (int t = 0; t < 100 && (q_a.size() != 0 || q_b.size() != 0); t++) idle(1);
        check("dut0_queue_drained", q_a.size(), 32'd0);
        check("dut1_queue_drained", q_b.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
